// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath width, default reset PC and the
// fetch controller state encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

endpackage

// File: rtl/pc_fetch_ctrl_next_pc_mux.sv
// Next-PC selection: redirect target, sequential increment, or hold.
// Kept standalone so the branch predictor can reuse it.
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] next_pc
);

  always_comb begin
    next_pc = pc;
    if (redirect) begin
      next_pc = redirect_pc;
    end else if (advance) begin
      next_pc = pc + XLEN'(1);
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and single-outstanding instruction fetch controller with a
// one-entry output buffer toward decode.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o,
  input  logic            if_ready_i
);

  logic [1:0]      state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] inflight_pc_reg, inflight_pc_next;
  logic            discard_reg, discard_next;
  logic [XLEN-1:0] if_pc_reg, if_instr_reg;
  logic            buf_load;
  logic            advance;

  assign advance = (state_reg == S_REQ) && imem_gnt_i;

  // A redirect always retargets the PC, whatever the state; the FSM only
  // decides whether an in-flight response must be thrown away.
  next_pc_mux u_next_pc_mux (
    .pc          (pc_reg),
    .redirect    (redirect_i),
    .redirect_pc (redirect_pc_i),
    .advance     (advance),
    .next_pc     (pc_next)
  );

  always_comb begin
    state_next       = state_reg;
    inflight_pc_next = inflight_pc_reg;
    discard_next     = discard_reg;
    buf_load         = 1'b0;
    case (state_reg)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (imem_gnt_i) begin
          inflight_pc_next = pc_reg;
          state_next       = S_RESP;
          if (redirect_i) begin
            discard_next = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (imem_rvalid_i) begin
          discard_next = 1'b0;
          if (discard_reg || redirect_i) begin
            state_next = S_REQ;
          end else begin
            buf_load   = 1'b1;
            state_next = S_OUT;
          end
        end else if (redirect_i) begin
          discard_next = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_i || if_ready_i) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      pc_reg          <= RESET_PC;
      inflight_pc_reg <= '0;
      discard_reg     <= 1'b0;
      if_pc_reg       <= '0;
      if_instr_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      inflight_pc_reg <= inflight_pc_next;
      discard_reg     <= discard_next;
      if (buf_load) begin
        if_pc_reg    <= inflight_pc_reg;
        if_instr_reg <= imem_rdata_i;
      end
    end
  end

  assign imem_req_o  = (state_reg == S_REQ);
  assign imem_addr_o = pc_reg;
  assign if_valid_o  = (state_reg == S_OUT);
  assign if_pc_o     = if_pc_reg;
  assign if_instr_o  = if_instr_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed scenarios plus a randomized run scored against a transaction-level
// model of the fetch stream.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_ready_i;

  int checks = 0;
  int errors = 0;

  pc_fetch_ctrl #(.RESET_PC(32'h100)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
    .if_ready_i    (if_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if_ready_i    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL reset_addr got %h want 00000100", imem_addr_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_valid_o); end
    checks++; if (if_pc_o !== 32'h0 || if_instr_o !== 32'h0) begin errors++; $display("FAIL reset_buf got %h/%h want 0/0", if_pc_o, if_instr_o); end
    rst = 1'b0;
    cyc();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin errors++; $display("FAIL first_req got %b@%h want 1@00000100", imem_req_o, imem_addr_o); end
    imem_gnt_i = 1'b1;
    cyc();
    imem_gnt_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL one_outstanding got %b want 0", imem_req_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013;
    cyc();
    imem_rvalid_i = 1'b0;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100 || if_instr_o !== 32'h13) begin errors++; $display("FAIL first_fetch got %b %h %h want 1 00000100 00000013", if_valid_o, if_pc_o, if_instr_o); end
    if_ready_i = 1'b1;
    cyc();
    if_ready_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h101 || if_valid_o !== 1'b0) begin errors++; $display("FAIL next_seq got %b@%h v%b want 1@00000101 v0", imem_req_o, imem_addr_o, if_valid_o); end
    $display("test_reset done");
  endtask

  task automatic test_redirect_wait();
    redirect_i = 1'b1; redirect_pc_i = 32'h104;
    cyc();
    redirect_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h104) begin errors++; $display("FAIL redir_req got %b@%h want 1@00000104", imem_req_o, imem_addr_o); end
    imem_gnt_i = 1'b1;
    cyc();
    imem_gnt_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    cyc();
    redirect_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL redir_wait_req got %b want 0", imem_req_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    cyc();
    imem_rvalid_i = 1'b0;
    checks++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin errors++; $display("FAIL redir_wait got v%b %b@%h want v0 1@00000200", if_valid_o, imem_req_o, imem_addr_o); end
    $display("test_redirect_wait done");
  endtask

  task automatic test_redirect_gnt();
    imem_gnt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h40;
    cyc();
    imem_gnt_i = 1'b0; redirect_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL redir_gnt_req got %b want 0", imem_req_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_5678;
    cyc();
    imem_rvalid_i = 1'b0;
    checks++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin errors++; $display("FAIL redir_gnt got v%b %b@%h want v0 1@00000040", if_valid_o, imem_req_o, imem_addr_o); end
    $display("test_redirect_gnt done");
  endtask

  task automatic test_backpressure();
    imem_gnt_i = 1'b1;
    cyc();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hCAFE_0040;
    cyc();
    imem_rvalid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (if_valid_o !== 1'b1 || if_pc_o !== 32'h40 || if_instr_o !== 32'hCAFE_0040 || imem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d got v%b %h %h r%b want v1 00000040 cafe0040 r0", i, if_valid_o, if_pc_o, if_instr_o, imem_req_o);
      end
      cyc();
    end
    if_ready_i = 1'b1;
    cyc();
    if_ready_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h41) begin errors++; $display("FAIL stall_release got %b@%h want 1@00000041", imem_req_o, imem_addr_o); end
    $display("test_backpressure done");
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    cyc();
    redirect_i = 1'b0;
    checks++; if (imem_addr_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_addr got %h want ffffffff", imem_addr_o); end
    imem_gnt_i = 1'b1;
    cyc();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0073;
    cyc();
    imem_rvalid_i = 1'b0;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_buf got v%b %h want v1 ffffffff", if_valid_o, if_pc_o); end
    if_ready_i = 1'b1;
    cyc();
    if_ready_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_next got %b@%h want 1@00000000", imem_req_o, imem_addr_o); end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    imem_gnt_i = 1'b1;
    cyc();
    imem_gnt_i = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h100 || if_valid_o !== 1'b0) begin errors++; $display("FAIL midrst got %b@%h v%b want 0@00000100 v0", imem_req_o, imem_addr_o, if_valid_o); end
    cyc();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin errors++; $display("FAIL midrst_req got %b@%h want 1@00000100", imem_req_o, imem_addr_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
    cyc();
    imem_rvalid_i = 1'b0;
    checks++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin errors++; $display("FAIL stale_rvalid got v%b %b@%h want v0 1@00000100", if_valid_o, imem_req_o, imem_addr_o); end
    $display("test_reset_mid done");
  endtask

  // Model view: the fetch stream is a run of consecutive addresses starting at
  // the last redirect target; a redirect kills whatever is in flight or buffered.
  task automatic test_random(input int ncycles);
    logic [31:0] m_next = 32'h100;
    logic        m_pend = 1'b0;
    logic        m_kill = 1'b0;
    logic [31:0] m_pend_pc = '0;
    logic        m_buf = 1'b0;
    logic [31:0] m_buf_pc = '0;
    int          mem_wait = 0;
    int          delivered = 0;
    logic        exp_req;
    logic        resp;
    logic [31:0] tgt;
    for (int c = 0; c < ncycles; c++) begin
      exp_req = !m_pend && !m_buf;
      checks++; if (imem_req_o !== exp_req) begin errors++; $display("FAIL rnd_req c%0d got %b want %b", c, imem_req_o, exp_req); end
      checks++; if (if_valid_o !== m_buf) begin errors++; $display("FAIL rnd_valid c%0d got %b want %b", c, if_valid_o, m_buf); end
      if (exp_req) begin
        checks++; if (imem_addr_o !== m_next) begin errors++; $display("FAIL rnd_addr c%0d got %h want %h", c, imem_addr_o, m_next); end
      end
      if (m_buf) begin
        checks++;
        if (if_pc_o !== m_buf_pc || if_instr_o !== mem_word(m_buf_pc)) begin
          errors++;
          $display("FAIL rnd_buf c%0d got %h %h want %h %h", c, if_pc_o, if_instr_o, m_buf_pc, mem_word(m_buf_pc));
        end
      end
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
      redirect_i    = ($urandom_range(0, 7) == 0);
      redirect_pc_i = tgt;
      imem_gnt_i    = ($urandom_range(0, 2) != 0);
      if_ready_i    = ($urandom_range(0, 1) != 0);
      resp = 1'b0;
      if (m_pend) begin
        resp = (mem_wait == 0);
        if (mem_wait > 0) mem_wait--;
        imem_rvalid_i = resp;
        imem_rdata_i  = resp ? mem_word(m_pend_pc) : $urandom;
      end else begin
        imem_rvalid_i = ($urandom_range(0, 7) == 0);
        imem_rdata_i  = $urandom;
      end
      if (exp_req) begin
        if (imem_gnt_i) begin
          m_pend    = 1'b1;
          m_pend_pc = m_next;
          m_kill    = redirect_i;
          mem_wait  = $urandom_range(0, 2);
          m_next    = redirect_i ? tgt : m_next + 32'd1;
        end else if (redirect_i) begin
          m_next = tgt;
        end
      end else if (m_pend) begin
        if (resp) begin
          m_pend = 1'b0;
          if (!m_kill && !redirect_i) begin
            m_buf    = 1'b1;
            m_buf_pc = m_pend_pc;
          end
        end else if (redirect_i) begin
          m_kill = 1'b1;
        end
        if (redirect_i) m_next = tgt;
      end else begin
        if (redirect_i) begin
          m_buf  = 1'b0;
          m_next = tgt;
        end else if (if_ready_i) begin
          m_buf = 1'b0;
          delivered++;
          $display("fetch pc=%h instr=%h", m_buf_pc, mem_word(m_buf_pc));
        end
      end
      cyc();
    end
    idle_inputs();
    $display("test_random done, %0d instructions delivered", delivered);
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    cyc();
    test_reset();
    test_redirect_wait();
    test_redirect_gnt();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
